// File: rtl/matriz_serial_loader.sv
// matriz_serial_loader
// Serial front end for the 5x5 determinant datapath. Signed 8-bit elements
// arrive one per accepted cycle in row-major order for a matrix of order
// N = 2..5. They are written into a 200-bit packed 5x5 grid whose unused rows
// and columns stay at identity, so the 5x5 determinant equals the NxN one.
// The finished matrix is held until the consumer takes it.
//
// Ports
//   clk         in   1    system clock, rising edge
//   rst         in   1    synchronous active-high reset
//   size        in   3    matrix order N, sampled on the first accept of a load
//   in_valid    in   1    element present on in_data
//   in_data     in   8    signed element, row-major
//   in_last     in   1    marks the final element of a load
//   in_ready    out  1    element accepted this cycle when in_valid is high
//   matriz_5x5  out  200  packed matrix, (r,c) at [199-8*(5r+c) -: 8]
//   mat_valid   out  1    matrix complete and stable
//   mat_ready   in   1    consumer accepts the matrix
//   elem_count  out  5    elements accepted in the current load
//   err         out  1    one-cycle protocol error pulse
module matriz_serial_loader (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   size,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic         in_ready,
  output logic [199:0] matriz_5x5,
  output logic         mat_valid,
  input  logic         mat_ready,
  output logic [4:0]   elem_count,
  output logic         err
);

  // Identity: a 1 followed by five zero bytes, repeated down the diagonal.
  localparam logic [199:0] IDENT = {8'h01, 40'h0, 8'h01, 40'h0, 8'h01,
                                    40'h0, 8'h01, 40'h0, 8'h01};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_next_s;
  logic [199:0]   matriz_r;
  logic [4:0]     elem_count_r;
  logic           err_r;
  logic [2:0]     n_r;
  logic [2:0]     row_r;
  logic [2:0]     col_r;

  logic           accept_s;
  logic           size_ok_s;
  logic [4:0]     nn_s;
  logic [4:0]     count_inc_s;
  logic           final_s;
  logic [4:0]     idx_s;
  logic [7:0]     lsb_s;
  logic           col_wrap_s;
  logic           wr_first_s;
  logic           wr_elem_s;
  logic           clear_s;
  logic           err_set_s;

  assign accept_s    = in_valid && in_ready;
  assign size_ok_s   = (size >= 3'd2) && (size <= 3'd5);
  assign nn_s        = {2'b00, n_r} * {2'b00, n_r};
  assign count_inc_s = elem_count_r + 5'd1;
  assign final_s     = (count_inc_s == nn_s);
  // Grid slot of the current element; (0,0) sits in the top byte.
  assign idx_s       = ({2'b00, row_r} * 5'd5) + {2'b00, col_r};
  assign lsb_s       = 8'd192 - {idx_s, 3'b000};
  assign col_wrap_s  = (col_r == (n_r - 3'd1));

  assign matriz_5x5  = matriz_r;
  assign elem_count  = elem_count_r;
  assign err         = err_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && size_ok_s && !in_last) begin
          state_next_s = ST_LOAD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (accept_s && final_s) begin
          state_next_s = ST_HOLD;
        end else if (accept_s && in_last) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_LOAD;
        end
      end
      ST_HOLD: begin
        if (mat_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_HOLD;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output and datapath-control decode.
  always_comb begin
    in_ready   = !rst && (state_r != ST_HOLD);
    mat_valid  = (state_r == ST_HOLD);
    wr_first_s = 1'b0;
    wr_elem_s  = 1'b0;
    clear_s    = 1'b0;
    err_set_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!accept_s) begin
          err_set_s = 1'b0;
        end else if (!size_ok_s) begin
          // Illegal order: the element is dropped.
          err_set_s = 1'b1;
        end else if (in_last) begin
          // One element can never complete a 2x2 or larger load.
          err_set_s = 1'b1;
          clear_s   = 1'b1;
        end else begin
          wr_first_s = 1'b1;
        end
      end
      ST_LOAD: begin
        if (!accept_s) begin
          err_set_s = 1'b0;
        end else if (final_s) begin
          // The load completes either way; a missing in_last is flagged.
          wr_elem_s = 1'b1;
          err_set_s = !in_last;
        end else if (in_last) begin
          err_set_s = 1'b1;
          clear_s   = 1'b1;
        end else begin
          wr_elem_s = 1'b1;
        end
      end
      ST_HOLD: begin
        if (mat_ready) begin
          clear_s = 1'b1;
        end else begin
          clear_s = 1'b0;
        end
      end
      default: clear_s = 1'b1;
    endcase
  end

  // Matrix storage, element counter, write position and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      matriz_r     <= IDENT;
      elem_count_r <= 5'd0;
      err_r        <= 1'b0;
      n_r          <= 3'd0;
      row_r        <= 3'd0;
      col_r        <= 3'd0;
    end else begin
      err_r <= err_set_s;
      if (clear_s) begin
        matriz_r     <= IDENT;
        elem_count_r <= 5'd0;
        row_r        <= 3'd0;
        col_r        <= 3'd0;
      end else if (wr_first_s) begin
        matriz_r[199:192] <= in_data;
        elem_count_r      <= 5'd1;
        n_r               <= size;
        row_r             <= 3'd0;
        col_r             <= 3'd1;
      end else if (wr_elem_s) begin
        matriz_r[lsb_s +: 8] <= in_data;
        elem_count_r         <= count_inc_s;
        if (col_wrap_s) begin
          col_r <= 3'd0;
          row_r <= row_r + 3'd1;
        end else begin
          col_r <= col_r + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_matriz_serial_loader.sv
module tb_matriz_serial_loader;

  localparam logic [199:0] IDENT = {8'h01, 40'h0, 8'h01, 40'h0, 8'h01,
                                    40'h0, 8'h01, 40'h0, 8'h01};

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   size;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_last;
  logic         in_ready;
  logic [199:0] matriz_5x5;
  logic         mat_valid;
  logic         mat_ready;
  logic [4:0]   elem_count;
  logic         err;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0]   elems [25];
  logic [199:0] exp_m;

  always #5 clk = ~clk;

  matriz_serial_loader dut (
    .clk        (clk),
    .rst        (rst),
    .size       (size),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .matriz_5x5 (matriz_5x5),
    .mat_valid  (mat_valid),
    .mat_ready  (mat_ready),
    .elem_count (elem_count),
    .err        (err)
  );

  task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [199:0] put(input logic [199:0] m, input int r, input int c,
                                       input logic [7:0] v);
    m[192 - 8*(5*r + c) +: 8] = v;
    return m;
  endfunction

  // Fraction-free (Bareiss) determinant of the packed 5x5 bus.
  function automatic longint det5(input logic [199:0] m);
    longint a [5][5];
    longint prev, sgn, t;
    int p;
    prev = 1; sgn = 1;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        a[r][c] = longint'($signed(m[192 - 8*(5*r + c) +: 8]));
    for (int k = 0; k < 4; k++) begin
      if (a[k][k] == 0) begin
        p = -1;
        for (int i = k + 1; i < 5; i++) if (p < 0 && a[i][k] != 0) p = i;
        if (p < 0) return 0;
        for (int j = 0; j < 5; j++) begin t = a[k][j]; a[k][j] = a[p][j]; a[p][j] = t; end
        sgn = -sgn;
      end
      for (int i = k + 1; i < 5; i++)
        for (int j = k + 1; j < 5; j++)
          a[i][j] = (a[i][j]*a[k][k] - a[i][k]*a[k][j]) / prev;
      prev = a[k][k];
    end
    return sgn * a[4][4];
  endfunction

  // Expected bus for an N-order load of elems[0..N*N-1].
  function automatic logic [199:0] build(input int n);
    logic [199:0] m;
    m = IDENT;
    for (int k = 0; k < n*n; k++) m = put(m, k / n, k % n, elems[k]);
    return m;
  endfunction

  // Streams elems[0..cnt-1] back to back from a negedge; in_last at last_idx.
  // size is scrambled after the first element to prove it is sampled once.
  task automatic load(input logic [2:0] sz, input int cnt, input int last_idx);
    for (int i = 0; i < cnt; i++) begin
      size     = (i == 0) ? sz : 3'd7;
      in_valid = 1'b1;
      in_data  = elems[i];
      in_last  = (i == last_idx);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic handoff(input string tag);
    mat_ready = 1'b1;
    @(negedge clk);
    mat_ready = 1'b0;
    check({tag, "_valid_low"}, 200'(mat_valid), 200'(1'b0));
    check({tag, "_ident"}, matriz_5x5, IDENT);
    check({tag, "_count0"}, 200'(elem_count), 200'(5'd0));
  endtask

  initial begin
    rst = 1'b1; size = 3'd0; in_valid = 1'b0; in_data = 8'h00;
    in_last = 1'b0; mat_ready = 1'b0;

    // 1: reset
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready0", 200'(in_ready), 200'(1'b0));
    rst = 1'b0;
    #1;
    check("rst_in_ready1", 200'(in_ready), 200'(1'b1));
    check("rst_mat_valid", 200'(mat_valid), 200'(1'b0));
    check("rst_count", 200'(elem_count), 200'(5'd0));
    check("rst_matrix", matriz_5x5, IDENT);
    check("rst_err", 200'(err), 200'(1'b0));

    // 2: 5x5 identity with (4,4)=2
    for (int k = 0; k < 25; k++) elems[k] = (k % 6 == 0) ? 8'h01 : 8'h00;
    elems[24] = 8'h02;
    load(3'd5, 25, 24);
    check("t2_valid", 200'(mat_valid), 200'(1'b1));
    check("t2_low_byte", 200'(matriz_5x5[7:0]), 200'(8'h02));
    check("t2_matrix", matriz_5x5, put(IDENT, 4, 4, 8'h02));
    check("t2_det", 200'(det5(matriz_5x5)), 200'(longint'(2)));
    check("t2_count", 200'(elem_count), 200'(5'd25));
    check("t2_err", 200'(err), 200'(1'b0));
    handoff("t2");

    // 3: 3x3 with -128 at (2,2)
    elems[0] = 8'd2; elems[1] = 8'd1; elems[2] = 8'd0;
    elems[3] = 8'd0; elems[4] = 8'd3; elems[5] = 8'd1;
    elems[6] = 8'd0; elems[7] = 8'd0; elems[8] = 8'h80;
    load(3'd3, 9, 8);
    exp_m = put(put(put(put(put(IDENT, 0, 0, 8'd2), 0, 1, 8'd1), 1, 1, 8'd3), 1, 2, 8'd1), 2, 2, 8'h80);
    check("t3_valid", 200'(mat_valid), 200'(1'b1));
    check("t3_matrix", matriz_5x5, exp_m);
    check("t3_det", 200'(det5(matriz_5x5)), 200'(longint'(-768)));
    check("t3_count", 200'(elem_count), 200'(5'd9));

    // 4: hold the 3x3 result with a pending element
    in_valid = 1'b1; in_data = 8'h55; size = 3'd2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_in_ready0", 200'(in_ready), 200'(1'b0));
      check("t4_stable", matriz_5x5, exp_m);
      check("t4_valid", 200'(mat_valid), 200'(1'b1));
    end
    check("t4_count", 200'(elem_count), 200'(5'd9));
    in_valid = 1'b0;
    handoff("t4");

    // 4b: full 5x5 held with a pending element keeps count at 25
    for (int k = 0; k < 25; k++) elems[k] = (k % 6 == 0) ? 8'h01 : 8'h00;
    load(3'd5, 25, 24);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4b_in_ready0", 200'(in_ready), 200'(1'b0));
      check("t4b_count25", 200'(elem_count), 200'(5'd25));
    end
    check("t4b_stable", matriz_5x5, IDENT);
    in_valid = 1'b0;
    handoff("t4b");

    // 5: early in_last on the 4th element of a 3x3 load
    for (int k = 0; k < 4; k++) elems[k] = 8'(k + 9);
    load(3'd3, 4, 3);
    check("t5_err", 200'(err), 200'(1'b1));
    check("t5_count", 200'(elem_count), 200'(5'd0));
    check("t5_no_valid", 200'(mat_valid), 200'(1'b0));
    check("t5_ident", matriz_5x5, IDENT);
    elems[0] = 8'd1; elems[1] = 8'd2; elems[2] = 8'd3; elems[3] = 8'd4;
    load(3'd2, 4, 3);
    check("t5_valid", 200'(mat_valid), 200'(1'b1));
    check("t5_err_clear", 200'(err), 200'(1'b0));
    check("t5_matrix", matriz_5x5, build(2));
    check("t5_det", 200'(det5(matriz_5x5)), 200'(longint'(-2)));
    check("t5_count", 200'(elem_count), 200'(5'd4));
    handoff("t5");

    // 5b: final element without in_last completes but flags err
    elems[0] = 8'd5; elems[1] = 8'd0; elems[2] = 8'd0; elems[3] = 8'd5;
    load(3'd2, 4, -1);
    check("t5b_valid", 200'(mat_valid), 200'(1'b1));
    check("t5b_err", 200'(err), 200'(1'b1));
    check("t5b_det", 200'(det5(matriz_5x5)), 200'(longint'(25)));
    @(negedge clk);
    check("t5b_err_pulse", 200'(err), 200'(1'b0));
    handoff("t5b");

    // 6: illegal size, then reset mid-load
    elems[0] = 8'h77;
    load(3'd6, 1, -1);
    check("t6_err", 200'(err), 200'(1'b1));
    check("t6_count", 200'(elem_count), 200'(5'd0));
    check("t6_ident", matriz_5x5, IDENT);
    for (int k = 0; k < 25; k++) elems[k] = 8'(k + 1);
    load(3'd5, 12, -1);
    check("t6_err_gone", 200'(err), 200'(1'b0));
    check("t6_partial", 200'(elem_count), 200'(5'd12));
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_count", 200'(elem_count), 200'(5'd0));
    check("t6_rst_ident", matriz_5x5, IDENT);
    check("t6_rst_valid", 200'(mat_valid), 200'(1'b0));
    check("t6_rst_ready", 200'(in_ready), 200'(1'b0));
    rst = 1'b0;
    // Upper-triangular 5x5, diagonal 1,-1,2,1,3 -> determinant -6.
    for (int k = 0; k < 25; k++) begin
      if (k / 5 == k % 5) elems[k] = 8'h00;
      else if (k % 5 > k / 5) elems[k] = 8'd7;
      else elems[k] = 8'd0;
    end
    elems[0] = 8'd1; elems[6] = 8'hFF; elems[12] = 8'd2; elems[18] = 8'd1; elems[24] = 8'd3;
    load(3'd5, 25, 24);
    check("t6_valid", 200'(mat_valid), 200'(1'b1));
    check("t6_matrix", matriz_5x5, build(5));
    check("t6_det", 200'(det5(matriz_5x5)), 200'(longint'(-6)));
    handoff("t6");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
